pe_reduce_arbiter: RTL



---
 rtl/pe_reduce_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pe_reduce_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_reduce_arbiter
// Purpose  : Grants left/right VPEncoder staging buffers into the shared
//            PEReducer through one output register, bounds the bundles in
//            flight and pulses o_finish once the job has fully drained.
// Options  : PE_ARB_ROUND_ROBIN_EN selects round-robin instead of left-first.
// Revision : 1.0 - initial release
// ============================================================================
module pe_reduce_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int LANES   = 3,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 10,
  parameter int MAX_OUT = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_enc_finish,
  input  logic                         i_left_valid,
  input  logic                         i_right_valid,
  output logic                         o_left_ack,
  output logic                         o_right_ack,
  input  logic [LANES*3*ADDR_W-1:0]    i_left_addr,
  input  logic [LANES*3*ADDR_W-1:0]    i_right_addr,
  input  logic [LANES*DATA_W-1:0]      i_left_w,
  input  logic [LANES*DATA_W-1:0]      i_right_w,
  input  logic [LANES*DATA_W-1:0]      i_left_ia,
  input  logic [LANES*DATA_W-1:0]      i_right_ia,
  output logic                         o_red_valid,
  input  logic                         i_red_ready,
  output logic [LANES*3*ADDR_W-1:0]    o_red_addr,
  output logic [LANES*DATA_W-1:0]      o_red_w,
  output logic [LANES*DATA_W-1:0]      o_red_ia,
  input  logic                         i_red_done,
  output logic                         o_busy,
  output logic                         o_finish,
  output logic [CNT_W-1:0]             o_issue_cnt,
  output logic                         o_err
);

  localparam int c_AW    = LANES * 3 * ADDR_W;
  localparam int c_DW    = LANES * DATA_W;
  localparam int c_ACC_W = $clog2(MAX_OUT + 1);
  localparam logic [c_ACC_W:0] c_MAX_OUT = (c_ACC_W + 1)'(MAX_OUT);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               w_run;
  logic               w_start_job;

  logic               r_red_valid;
  logic [c_AW-1:0]    r_red_addr;
  logic [c_DW-1:0]    r_red_w;
  logic [c_DW-1:0]    r_red_ia;
  logic [c_ACC_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic               r_err;
  logic               r_fin_seen;

  logic               w_accept;
  logic               w_done_ok;
  logic [c_ACC_W:0]   w_acc_sum;
  logic               w_slot_ok;
  logic               w_grant;
  logic               w_pick_right;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (i_start) w_next_state = c_RUN;
      c_RUN:  if (r_fin_seen && !i_left_valid && !i_right_valid &&
                  !r_red_valid && (r_acc_cnt == '0))
                w_next_state = c_DONE;
      c_DONE: w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != c_IDLE);
    o_finish    = (r_state == c_DONE);
    w_run       = (r_state == c_RUN);
    w_start_job = (r_state == c_IDLE) && i_start;
  end

  // ---------------- grant ----------------
  // A same-cycle i_red_done is deliberately left out so acks never depend on it.
  assign w_accept  = r_red_valid & i_red_ready;
  assign w_done_ok = i_red_done & (r_acc_cnt != '0);
  assign w_acc_sum = {1'b0, r_acc_cnt} + {{c_ACC_W{1'b0}}, w_accept};
  assign w_slot_ok = (!r_red_valid || i_red_ready) && (w_acc_sum < c_MAX_OUT);
  assign w_grant   = w_run & (i_left_valid | i_right_valid) & w_slot_ok;

`ifdef PE_ARB_ROUND_ROBIN_EN
  logic r_ptr_right;

  assign w_pick_right = i_right_valid & (~i_left_valid | r_ptr_right);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            r_ptr_right <= 1'b0;
    else if (w_start_job) r_ptr_right <= 1'b0;
    else if (w_grant)     r_ptr_right <= ~w_pick_right;
  end
`else
  assign w_pick_right = i_right_valid & ~i_left_valid;
`endif

  assign o_left_ack  = w_grant & ~w_pick_right;
  assign o_right_ack = w_grant &  w_pick_right;

  // ---------------- output register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_red_valid <= 1'b0;
      r_red_addr  <= '0;
      r_red_w     <= '0;
      r_red_ia    <= '0;
    end else if (w_grant) begin
      r_red_valid <= 1'b1;
      r_red_addr  <= w_pick_right ? i_right_addr : i_left_addr;
      r_red_w     <= w_pick_right ? i_right_w    : i_left_w;
      r_red_ia    <= w_pick_right ? i_right_ia   : i_left_ia;
    end else if (w_accept) begin
      r_red_valid <= 1'b0;
    end
  end

  // ---------------- job counters ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc_cnt   <= '0;
      r_issue_cnt <= '0;
      r_err       <= 1'b0;
      r_fin_seen  <= 1'b0;
    end else if (w_start_job) begin
      r_acc_cnt   <= '0;
      r_issue_cnt <= '0;
      r_err       <= 1'b0;
      r_fin_seen  <= i_enc_finish;
    end else begin
      case ({w_accept, w_done_ok})
        2'b10:   r_acc_cnt <= r_acc_cnt + c_ACC_W'(1);
        2'b01:   r_acc_cnt <= r_acc_cnt - c_ACC_W'(1);
        default: r_acc_cnt <= r_acc_cnt;
      endcase
      if (w_accept)                         r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (i_red_done && (r_acc_cnt == '0))  r_err       <= 1'b1;
      if (w_run && i_enc_finish)            r_fin_seen  <= 1'b1;
    end
  end

  assign o_red_valid = r_red_valid;
  assign o_red_addr  = r_red_addr;
  assign o_red_w     = r_red_w;
  assign o_red_ia    = r_red_ia;
  assign o_issue_cnt = r_issue_cnt;
  assign o_err       = r_err;

endmodule
`default_nettype wire
